// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and oversampling constants.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_t;

  localparam int unsigned OVERSAMPLE = 16;
  localparam int unsigned MID_TICK   = 7;

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchroniser for a single asynchronous level signal.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  // Two back-to-back flops; reset value lets the caller pick the idle level.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx_oversample.sv
// UART receiver driven by a 16x oversampling strobe; LSB-first, optional parity.
module uart_rx_oversample
  import uart_pkg::*;
#(
  parameter int unsigned DBIT       = 8,
  parameter int unsigned SB_TICK    = 16,
  parameter int unsigned PARITY_EN  = 0,
  parameter int unsigned PARITY_ODD = 0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            rx,
  input  logic            s_tick,
  output logic [DBIT-1:0] dout,
  output logic            rx_done_tick,
  output logic            frame_err,
  output logic            parity_err,
  output logic            busy
);

  localparam int unsigned SW = ($clog2(SB_TICK) < 4) ? 4 : $clog2(SB_TICK);
  localparam int unsigned NW = ($clog2(DBIT) < 1) ? 1 : $clog2(DBIT);

  localparam logic [SW-1:0] S_MID  = SW'(MID_TICK);
  localparam logic [SW-1:0] S_BIT  = SW'(OVERSAMPLE - 1);
  localparam logic [SW-1:0] S_STOP = SW'(SB_TICK - 1);
  localparam logic [NW-1:0] N_LAST = NW'(DBIT - 1);
  localparam logic          P_EN   = (PARITY_EN != 0);
  localparam logic          P_ODD  = (PARITY_ODD != 0);

  rx_state_t        state_q, state_d;
  logic [SW-1:0]    s_q, s_d;
  logic [NW-1:0]    n_q, n_d;
  logic [DBIT-1:0]  b_q, b_d;
  logic             p_q, p_d;
  logic [DBIT-1:0]  dout_d;
  logic             frame_err_d;
  logic             parity_err_d;
  logic             done_d;
  logic             rx_s;

  // Bring the serial line into the clk domain; idle-high reset value.
  sync_2ff #(
    .RESET_VAL (1'b1)
  ) u_rx_sync (
    .clk   (clk),
    .reset (reset),
    .d     (rx),
    .q     (rx_s)
  );

  // State, counters, shift register and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      s_q          <= '0;
      n_q          <= '0;
      b_q          <= '0;
      p_q          <= 1'b0;
      dout         <= '0;
      frame_err    <= 1'b0;
      parity_err   <= 1'b0;
      rx_done_tick <= 1'b0;
      busy         <= 1'b0;
    end else begin
      state_q      <= state_d;
      s_q          <= s_d;
      n_q          <= n_d;
      b_q          <= b_d;
      p_q          <= p_d;
      dout         <= dout_d;
      frame_err    <= frame_err_d;
      parity_err   <= parity_err_d;
      rx_done_tick <= done_d;
      busy         <= (state_d != IDLE);
    end
  end

  // Next-state logic: everything except start detection waits for s_tick.
  always_comb begin
    state_d      = state_q;
    s_d          = s_q;
    n_d          = n_q;
    b_d          = b_q;
    p_d          = p_q;
    dout_d       = dout;
    frame_err_d  = frame_err;
    parity_err_d = parity_err;
    done_d       = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (!rx_s) begin
          state_d = START;
          s_d     = '0;
        end
      end

      START: begin
        if (s_tick) begin
          if (s_q == S_MID) begin
            if (!rx_s) begin
              state_d = DATA;
              s_d     = '0;
              n_d     = '0;
            end else begin
              state_d = IDLE;
            end
          end else begin
            s_d = s_q + SW'(1);
          end
        end
      end

      DATA: begin
        if (s_tick) begin
          if (s_q == S_BIT) begin
            s_d = '0;
            b_d = {rx_s, b_q[DBIT-1:1]};
            if (n_q == N_LAST) begin
              state_d = P_EN ? PARITY : STOP;
            end else begin
              n_d = n_q + NW'(1);
            end
          end else begin
            s_d = s_q + SW'(1);
          end
        end
      end

      PARITY: begin
        if (s_tick) begin
          if (s_q == S_BIT) begin
            p_d     = rx_s;
            s_d     = '0;
            state_d = STOP;
          end else begin
            s_d = s_q + SW'(1);
          end
        end
      end

      STOP: begin
        if (s_tick) begin
          if (s_q == S_STOP) begin
            dout_d       = b_q;
            frame_err_d  = ~rx_s;
            parity_err_d = P_EN & ((^b_q) ^ p_q ^ P_ODD);
            done_d       = 1'b1;
            state_d      = IDLE;
          end else begin
            s_d = s_q + SW'(1);
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule
